// File: rtl/cover_seq.sv
// Passive sequence-coverage monitor: detects four fixed orderings on event lines a..d and
// reports a registered hit pulse, a saturating counter and a sticky covered flag per sequence.
module cover_seq #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             d,
  input  logic             clr,
  output logic [3:0]       hit,
  output logic [3:0]       covered,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2,
  output logic [CNT_W-1:0] cnt3
);

  // r_x_hist[k] holds the value of x sampled k+1 edges before the current one
  logic [3:0]       r_a_hist;
  logic             r_b_hist;
  logic [2:0]       r_c_hist;
  logic [3:0]       r_hit;
  logic [3:0]       r_covered;
  logic [CNT_W-1:0] r_cnt [4];
  logic [3:0]       w_done;

  always_comb begin
    w_done    = 4'b0000;
    w_done[0] = r_a_hist[0] & b;
    w_done[1] = r_a_hist[1] & r_b_hist & c;
    w_done[2] = d & (|r_a_hist);
    w_done[3] = d & (&r_c_hist);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_hist <= 4'b0000;
      r_b_hist <= 1'b0;
      r_c_hist <= 3'b000;
      r_hit    <= 4'b0000;
    end else begin
      r_a_hist <= {r_a_hist[2:0], a};
      r_b_hist <= b;
      r_c_hist <= {r_c_hist[1:0], c};
      r_hit    <= w_done;
    end
  end

  // clr wins over a hit completing in the same cycle; the hit pulse itself is unaffected
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_covered <= 4'b0000;
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else if (clr) begin
      r_covered <= 4'b0000;
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else begin
      r_covered <= r_covered | w_done;
      for (int i = 0; i < 4; i++) begin
        if (w_done[i] && (r_cnt[i] != {CNT_W{1'b1}})) r_cnt[i] <= r_cnt[i] + 1'b1;
      end
    end
  end

  assign hit     = r_hit;
  assign covered = r_covered;
  assign cnt0    = r_cnt[0];
  assign cnt1    = r_cnt[1];
  assign cnt2    = r_cnt[2];
  assign cnt3    = r_cnt[3];

endmodule

// File: tb/tb_cover_seq.sv
// Bench for cover_seq: directed scenarios plus random traffic checked against a
// sample-history model, on a wide-counter and a 2-bit-counter instance side by side.
module tb_cover_seq;

  logic        clk;
  logic        rst_n;
  logic        a, b, c, d, clr;
  logic [3:0]  hit, covered, hit_s, covered_s;
  logic [15:0] cnt0, cnt1, cnt2, cnt3;
  logic [1:0]  cnt0_s, cnt1_s, cnt2_s, cnt3_s;

  int total;
  int bad;

  // model state: samples since reset (bit0=a,1=b,2=c,3=d) and hits since last clear
  logic [3:0] samp_q[$];
  int         tot_hits[4];
  logic [3:0] exp_hit;
  logic [3:0] exp_cov;

  cover_seq #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d), .clr(clr),
    .hit(hit), .covered(covered), .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3)
  );

  cover_seq #(.CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d), .clr(clr),
    .hit(hit_s), .covered(covered_s), .cnt0(cnt0_s), .cnt1(cnt1_s), .cnt2(cnt2_s), .cnt3(cnt3_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [3:0] past(input int k);
    if (k < samp_q.size()) return samp_q[samp_q.size() - 1 - k];
    return 4'b0000;
  endfunction

  function automatic logic [31:0] sat(input int n, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (n > mx) ? mx : n;
  endfunction

  task automatic model_clear();
    samp_q.delete();
    for (int i = 0; i < 4; i++) tot_hits[i] = 0;
    exp_hit = 4'b0000;
    exp_cov = 4'b0000;
  endtask

  task automatic check_model(input string where);
    chk({where, ":hit"},       hit,       exp_hit);
    chk({where, ":covered"},   covered,   exp_cov);
    chk({where, ":cnt0"},      cnt0,      sat(tot_hits[0], 16));
    chk({where, ":cnt1"},      cnt1,      sat(tot_hits[1], 16));
    chk({where, ":cnt2"},      cnt2,      sat(tot_hits[2], 16));
    chk({where, ":cnt3"},      cnt3,      sat(tot_hits[3], 16));
    chk({where, ":hit_s"},     hit_s,     exp_hit);
    chk({where, ":covered_s"}, covered_s, exp_cov);
    chk({where, ":cnt0_s"},    cnt0_s,    sat(tot_hits[0], 2));
    chk({where, ":cnt1_s"},    cnt1_s,    sat(tot_hits[1], 2));
    chk({where, ":cnt2_s"},    cnt2_s,    sat(tot_hits[2], 2));
    chk({where, ":cnt3_s"},    cnt3_s,    sat(tot_hits[3], 2));
  endtask

  // one clock cycle: drive, let the edge sample, update the model, check #1 later
  task automatic cycle(input logic ia, input logic ib, input logic ic, input logic id,
                       input logic iclr);
    logic [3:0] p0, p1, p2, p3, p4;
    a = ia; b = ib; c = ic; d = id; clr = iclr;
    @(posedge clk);
    samp_q.push_back({id, ic, ib, ia});
    if (samp_q.size() > 8) void'(samp_q.pop_front());
    p0 = past(0); p1 = past(1); p2 = past(2); p3 = past(3); p4 = past(4);
    exp_hit[0] = p1[0] & p0[1];
    exp_hit[1] = p2[0] & p1[1] & p0[2];
    exp_hit[2] = p0[3] & (p1[0] | p2[0] | p3[0] | p4[0]);
    exp_hit[3] = p3[2] & p2[2] & p1[2] & p0[3];
    for (int i = 0; i < 4; i++) begin
      if (iclr) tot_hits[i] = 0;
      else if (exp_hit[i]) tot_hits[i]++;
    end
    exp_cov = iclr ? 4'b0000 : (exp_cov | exp_hit);
    #1;
    check_model("cyc");
  endtask

  task automatic do_reset(input string where);
    rst_n = 1'b0;
    a = 0; b = 0; c = 0; d = 0; clr = 0;
    #1;
    model_clear();
    check_model(where);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    a = 0; b = 0; c = 0; d = 0; clr = 0;
    model_clear();
    #2;
    do_reset("reset");

    // a, b, idle ten times
    for (int r = 0; r < 10; r++) begin
      cycle(1, 0, 0, 0, 0);
      chk("s0_pre", hit[0], 1'b0);
      cycle(0, 1, 0, 0, 0);
      chk("s0_pulse", hit[0], 1'b1);
      cycle(0, 0, 0, 0, 0);
      chk("s0_width", hit[0], 1'b0);
    end
    chk("s0_cnt", cnt0, 10);
    chk("s0_cov", covered, 4'b0001);
    chk("s0_cnt1", cnt1, 0);
    chk("s0_cnt2", cnt2, 0);
    chk("s0_cnt3", cnt3, 0);

    // a, b, c consecutively
    do_reset("rst_s1");
    cycle(1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    chk("s1_b", hit, 4'b0001);
    cycle(0, 0, 1, 0, 0);
    chk("s1_c", hit, 4'b0010);
    chk("s1_cnt0", cnt0, 1);
    chk("s1_cnt1", cnt1, 1);
    chk("s1_cov", covered, 4'b0011);

    // single a then d held six cycles: window covers four of them
    do_reset("rst_s2");
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      cycle(0, 0, 0, 1, 0);
      chk("s2_win", hit[2], (i < 4) ? 1'b1 : 1'b0);
    end
    chk("s2_cnt", cnt2, 4);
    chk("s2_cov", covered[2], 1'b1);

    // c x3 then d hits; c x2 then d does not
    do_reset("rst_s3");
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 0, 1, 0);
    chk("s3_hit", hit[3], 1'b1);
    cycle(0, 0, 0, 0, 0);
    chk("s3_cnt", cnt3, 1);
    for (int i = 0; i < 2; i++) cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 0, 1, 0);
    chk("s3_short", hit[3], 1'b0);
    chk("s3_cnt2", cnt3, 1);

    // saturation on the 2-bit instance, then clr
    do_reset("rst_sat");
    for (int r = 0; r < 5; r++) begin
      cycle(1, 0, 0, 0, 0);
      cycle(0, 1, 0, 0, 0);
      cycle(0, 0, 0, 0, 0);
    end
    chk("sat_cnt0_s", cnt0_s, 3);
    chk("sat_cnt0", cnt0, 5);
    cycle(0, 0, 0, 0, 1);
    chk("clr_cnt0_s", cnt0_s, 0);
    chk("clr_cov_s", covered_s, 4'b0000);
    cycle(1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    chk("clr_next_s", cnt0_s, 1);

    // clr coinciding with a completion: pulse kept, count discarded
    cycle(1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 1);
    chk("clr_hit", hit[0], 1'b1);
    chk("clr_drop", cnt0, 0);

    // reset between a and b aborts the match
    do_reset("rst_mid0");
    cycle(1, 0, 0, 0, 0);
    do_reset("rst_mid");
    cycle(0, 1, 0, 0, 0);
    chk("mid_hit", hit, 4'b0000);
    chk("mid_cov", covered, 4'b0000);
    chk("mid_cnt0", cnt0, 0);

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) do_reset("rst_rand");
      cycle(($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 1) == 0), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 39) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
